// File: rtl/mips_intr_pkg.sv
// Shared constants for the MIPS interrupt controller: register map, FSM encoding, default vector base.
// Optional preemption is enabled by defining NESTED_INTR_EN.
package mips_intr_pkg;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [1:0] ADDR_VEC  = 2'd3;

    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder: id_o is the smallest set bit of req_i, valid_o flags any set bit.
module intr_prio_enc #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req_i,
    output logic [IDW-1:0] id_o,
    output logic           valid_o
);

    // Scanning downward lets the lowest set index overwrite all higher ones.
    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = IDW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_intr_ctrl.sv
// Prioritised, maskable interrupt controller in front of the MIPS CPU intr/inta handshake.
// Define NESTED_INTR_EN to let higher-priority channels preempt a source in service.
module mips_intr_ctrl
    import mips_intr_pkg::*;
#(
    parameter int          N_IRQ           = 8,
    parameter logic [31:0] VEC_BASE        = VEC_BASE_DEFAULT,
    parameter int          VEC_STRIDE_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             intr,
    input  logic             inta,
    input  logic             io_cs,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [1:0]       io_addr,
    input  logic [31:0]      io_d_in,
    output logic [31:0]      io_out,
    output logic [31:0]      vector,
    output logic             in_service
);

    localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_e             state_q, state_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic [N_IRQ-1:0]   pend_q, pend_d;
    logic [N_IRQ-1:0]   mode_q, mode_d;
    logic [N_IRQ-1:0]   irq_prev_q;
    logic               intr_q, intr_d;
    logic               in_service_q, in_service_d;
    logic [31:0]        vector_q, vector_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;

    logic [N_IRQ-1:0]   qual;
    logic [N_IRQ-1:0]   ack_mask;
    logic [N_IRQ-1:0]   w1c;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     ack_id;
    logic               win_vld;
    logic               ack;
    logic               wr_en;
    logic               eoi;
    logic               stack_empty;
    logic               push;
    logic               pop;
    logic               unused_bits;

    function automatic logic [31:0] vec_of(input logic [IDW-1:0] id);
        return VEC_BASE + (32'(id) << VEC_STRIDE_LOG2);
    endfunction

    assign wr_en       = io_cs & io_wr;
    assign eoi         = wr_en && (io_addr == ADDR_VEC);
    assign qual        = pend_q & mask_q;
    assign unused_bits = ^io_d_in;

    intr_prio_enc #(.N(N_IRQ), .IDW(IDW)) u_enc (
        .req_i   (qual),
        .id_o    (win_id),
        .valid_o (win_vld)
    );

`ifdef NESTED_INTR_EN
    localparam int SPW = $clog2(N_IRQ + 1);

    logic [IDW-1:0]   stack_q [N_IRQ];
    logic [SPW-1:0]   sp_q;
    logic [IDW-1:0]   stack_top;
    logic [N_IRQ-1:0] below_cur;
    logic [IDW-1:0]   hi_id;
    logic             hi_vld;

    // Only channels strictly more urgent than the one in service may preempt it.
    always_comb begin
        below_cur = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            below_cur[i] = (i < int'(cur_id_q));
        end
    end

    intr_prio_enc #(.N(N_IRQ), .IDW(IDW)) u_hi_enc (
        .req_i   (qual & below_cur),
        .id_o    (hi_id),
        .valid_o (hi_vld)
    );

    assign stack_empty = (sp_q == '0);
    assign stack_top   = stack_q[sp_q - SPW'(1)];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < N_IRQ; i++) begin
                stack_q[i] <= '0;
            end
        end else if (pop) begin
            sp_q <= sp_q - SPW'(1);
        end else if (push) begin
            stack_q[sp_q] <= cur_id_q;
            sp_q          <= sp_q + SPW'(1);
        end
    end
`else
    assign stack_empty = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = REQ;
            REQ: begin
                if (!win_vld) begin
                    state_d = IDLE;
                end else if (inta) begin
                    state_d = SVC;
                end
            end
            SVC:     if (eoi && stack_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // intr is registered, so every path decides what it should read next cycle.
    always_comb begin
        intr_d       = 1'b0;
        in_service_d = in_service_q;
        vector_d     = vector_q;
        cur_id_d     = cur_id_q;
        ack          = 1'b0;
        ack_id       = win_id;
        push         = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: intr_d = win_vld;
            REQ: begin
                if (win_vld && inta) begin
                    ack          = 1'b1;
                    cur_id_d     = win_id;
                    vector_d     = vec_of(win_id);
                    in_service_d = 1'b1;
                end else begin
                    intr_d = win_vld;
                end
            end
            SVC: begin
                if (eoi) begin
                    if (stack_empty) begin
                        in_service_d = 1'b0;
                    end else begin
`ifdef NESTED_INTR_EN
                        pop      = 1'b1;
                        cur_id_d = stack_top;
                        vector_d = vec_of(stack_top);
`endif
                    end
                end
`ifdef NESTED_INTR_EN
                else if (intr_q && inta && hi_vld) begin
                    ack      = 1'b1;
                    ack_id   = hi_id;
                    push     = 1'b1;
                    cur_id_d = hi_id;
                    vector_d = vec_of(hi_id);
                end else begin
                    intr_d = hi_vld;
                end
`endif
            end
            default: intr_d = 1'b0;
        endcase
    end

    // Edge channels latch rising edges and clear on W1C or ack, with a fresh edge winning;
    // level channels simply track the line.
    always_comb begin
        for (int i = 0; i < N_IRQ; i++) begin
            ack_mask[i] = ack && (ack_id == IDW'(i));
        end
        w1c    = (wr_en && (io_addr == ADDR_PEND)) ? io_d_in[N_IRQ-1:0] : '0;
        pend_d = (mode_q & ((pend_q & ~(w1c | ack_mask)) | (irq_in & ~irq_prev_q)))
               | (~mode_q & irq_in);
        mask_d = (wr_en && (io_addr == ADDR_MASK)) ? io_d_in[N_IRQ-1:0] : mask_q;
        mode_d = (wr_en && (io_addr == ADDR_MODE)) ? io_d_in[N_IRQ-1:0] : mode_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q       <= '0;
            pend_q       <= '0;
            mode_q       <= '0;
            irq_prev_q   <= '0;
            intr_q       <= 1'b0;
            in_service_q <= 1'b0;
            vector_q     <= VEC_BASE;
            cur_id_q     <= '0;
        end else begin
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            mode_q       <= mode_d;
            irq_prev_q   <= irq_in;
            intr_q       <= intr_d;
            in_service_q <= in_service_d;
            vector_q     <= vector_d;
            cur_id_q     <= cur_id_d;
        end
    end

    always_comb begin
        io_out = '0;
        if (io_cs && io_rd) begin
            case (io_addr)
                ADDR_MASK: io_out[N_IRQ-1:0] = mask_q;
                ADDR_PEND: io_out[N_IRQ-1:0] = pend_q;
                ADDR_MODE: io_out[N_IRQ-1:0] = mode_q;
                default:   io_out            = vector_q;
            endcase
        end
    end

    assign intr       = intr_q;
    assign vector     = vector_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_mips_intr_ctrl.sv
// Self-checking bench for mips_intr_ctrl: directed scenarios, then random traffic against a reference model.
// Preemption scenarios switch with NESTED_INTR_EN.
module tb_mips_intr_ctrl;

    localparam int          N  = 8;
    localparam logic [31:0] VB = 32'h0000_0200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic          inta = 1'b0;
    logic          io_cs = 1'b0;
    logic          io_rd = 1'b0;
    logic          io_wr = 1'b0;
    logic [1:0]    io_addr = 2'd0;
    logic [31:0]   io_d_in = '0;
    logic          intr;
    logic [31:0]   io_out;
    logic [31:0]   vector;
    logic          in_service;

    int checks = 0;
    int errors = 0;

    // Reference model state: registers as plain words, handshake as two flags.
    logic [31:0] mPend, mMask, mMode, mPrev, mVec;
    bit          mAsking, mServing;

    mips_intr_ctrl #(.N_IRQ(N)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .irq_in     (irq_in),
        .intr       (intr),
        .inta       (inta),
        .io_cs      (io_cs),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_addr    (io_addr),
        .io_d_in    (io_d_in),
        .io_out     (io_out),
        .vector     (vector),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPend = '0; mMask = '0; mMode = '0; mPrev = '0; mVec = VB;
        mAsking = 1'b0; mServing = 1'b0;
    endtask

    // One clock of the controller's rules, evaluated from the inputs present at the edge.
    task automatic modelStep();
        logic [31:0] q, np, irq32;
        int  w;
        bit  wr, ack;
        irq32 = 32'(irq_in);
        wr    = io_cs && io_wr;
        ack   = 1'b0;
        q     = mPend & mMask;
        w     = -1;
        for (int i = N - 1; i >= 0; i--) if (q[i]) w = i;
        if (mServing) begin
            if (wr && io_addr == 2'd3) mServing = 1'b0;
        end else if (mAsking) begin
            if (w < 0) mAsking = 1'b0;
            else if (inta) begin
                ack = 1'b1; mAsking = 1'b0; mServing = 1'b1;
                mVec = VB + 32'(w * 4);
            end
        end else if (w >= 0) begin
            mAsking = 1'b1;
        end
        np = '0;
        for (int i = 0; i < N; i++) begin
            if (mMode[i]) begin
                if (irq32[i] && !mPrev[i]) np[i] = 1'b1;
                else if ((wr && io_addr == 2'd1 && io_d_in[i]) || (ack && w == i)) np[i] = 1'b0;
                else np[i] = mPend[i];
            end else begin
                np[i] = irq32[i];
            end
        end
        mPend = np;
        if (wr && io_addr == 2'd0) mMask = io_d_in & 32'h0000_00FF;
        if (wr && io_addr == 2'd2) mMode = io_d_in & 32'h0000_00FF;
        mPrev = irq32;
    endtask

    // Drive one clock worth of inputs, step the model at the edge, land on the next falling edge.
    task automatic applyStimulus(input logic [N-1:0] irq, input logic ack, input logic wr,
                                 input logic [1:0] addr, input logic [31:0] data);
        irq_in  = irq;
        inta    = ack;
        io_cs   = wr;
        io_wr   = wr;
        io_addr = addr;
        io_d_in = data;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        inta  = 1'b0;
        io_cs = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] val);
        io_cs   = 1'b1;
        io_rd   = 1'b1;
        io_addr = addr;
        #1;
        val   = io_out;
        io_cs = 1'b0;
        io_rd = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [N-1:0] rIrq;
        int op;
        modelReset();
        #12;
        checkOutput("reset intr", 32'(intr), 32'd0);
        checkOutput("reset in_service", 32'(in_service), 32'd0);
        checkOutput("reset vector", vector, VB);
        @(negedge clk);
        readReg(2'd0, rd); checkOutput("reset MASK", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single edge channel round trip
        applyStimulus(8'h00, 0, 1, 2'd0, 32'h01);
        applyStimulus(8'h00, 0, 1, 2'd2, 32'h01);
        applyStimulus(8'h01, 0, 0, 2'd0, 32'h0);
        checkOutput("t1 intr after 1 cycle", 32'(intr), 32'd0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("t1 intr after 2 cycles", 32'(intr), 32'd1);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("t1 vector", vector, 32'h200);
        checkOutput("t1 in_service", 32'(in_service), 32'd1);
        checkOutput("t1 intr after ack", 32'(intr), 32'd0);
        readReg(2'd1, rd); checkOutput("t1 PEND after ack", rd, 32'd0);
        @(negedge clk);
        applyStimulus(8'h00, 0, 1, 2'd3, 32'h0);
        checkOutput("t1 in_service after EOI", 32'(in_service), 32'd0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("t1 intr stays low", 32'(intr), 32'd0);

        // Two simultaneous edges are served in priority order
        applyStimulus(8'h00, 0, 1, 2'd0, 32'hFF);
        applyStimulus(8'h00, 0, 1, 2'd2, 32'hFF);
        applyStimulus(8'h24, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("t2 intr", 32'(intr), 32'd1);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("t2 first vector", vector, 32'h208);
        applyStimulus(8'h00, 0, 1, 2'd3, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("t2 intr reasserts", 32'(intr), 32'd1);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("t2 second vector", vector, 32'h214);
        applyStimulus(8'h00, 0, 1, 2'd3, 32'h0);

        // Level channel held high, then dropped before ack
        applyStimulus(8'h00, 0, 1, 2'd2, 32'hF7);
        applyStimulus(8'h00, 0, 1, 2'd0, 32'h08);
        applyStimulus(8'h08, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h08, 0, 0, 2'd0, 32'h0);
        checkOutput("t3 intr", 32'(intr), 32'd1);
        applyStimulus(8'h08, 1, 0, 2'd0, 32'h0);
        checkOutput("t3 vector", vector, 32'h20C);
        applyStimulus(8'h08, 0, 1, 2'd3, 32'h0);
        applyStimulus(8'h08, 0, 0, 2'd0, 32'h0);
        checkOutput("t3 intr reasserts", 32'(intr), 32'd1);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("t3 intr falls", 32'(intr), 32'd0);
        checkOutput("t3 vector held", vector, 32'h20C);

        // Masking a requested channel withdraws intr but keeps it pending
        applyStimulus(8'h00, 0, 1, 2'd2, 32'hFF);
        applyStimulus(8'h00, 0, 1, 2'd0, 32'hFF);
        applyStimulus(8'h02, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("t4 intr", 32'(intr), 32'd1);
        applyStimulus(8'h00, 0, 1, 2'd0, 32'h00);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("t4 intr after mask", 32'(intr), 32'd0);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("t4 stray inta in_service", 32'(in_service), 32'd0);
        checkOutput("t4 vector unchanged", vector, 32'h20C);
        readReg(2'd1, rd); checkOutput("t4 PEND", rd, 32'h02);
        @(negedge clk);
        applyStimulus(8'h00, 0, 1, 2'd1, 32'h02);

        // A new edge beats a simultaneous W1C
        applyStimulus(8'h10, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        readReg(2'd1, rd); checkOutput("t5 PEND set", rd, 32'h10);
        @(negedge clk);
        applyStimulus(8'h10, 0, 1, 2'd1, 32'h10);
        readReg(2'd1, rd); checkOutput("t5 set wins over W1C", rd, 32'h10);
        @(negedge clk);
        applyStimulus(8'h00, 0, 1, 2'd1, 32'h10);
        readReg(2'd1, rd); checkOutput("t5 W1C alone clears", rd, 32'h0);
        @(negedge clk);

        // Higher-priority edge while channel 4 is in service
        applyStimulus(8'h00, 0, 1, 2'd0, 32'hFF);
        applyStimulus(8'h10, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("t6 vector ch4", vector, 32'h210);
        applyStimulus(8'h02, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
`ifdef NESTED_INTR_EN
        checkOutput("n intr preempt", 32'(intr), 32'd1);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("n nested vector", vector, 32'h204);
        checkOutput("n nested in_service", 32'(in_service), 32'd1);
        applyStimulus(8'h00, 0, 1, 2'd3, 32'h0);
        checkOutput("n restored vector", vector, 32'h210);
        checkOutput("n in_service after pop", 32'(in_service), 32'd1);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("n intr after pop", 32'(intr), 32'd0);
        applyStimulus(8'h00, 0, 1, 2'd3, 32'h0);
        checkOutput("n in_service final", 32'(in_service), 32'd0);
`else
        checkOutput("np no preempt", 32'(intr), 32'd0);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("np inta ignored", vector, 32'h210);
        applyStimulus(8'h00, 0, 1, 2'd3, 32'h0);
        checkOutput("np in_service after EOI", 32'(in_service), 32'd0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        checkOutput("np intr for waiting ch1", 32'(intr), 32'd1);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("np vector ch1", vector, 32'h204);
        applyStimulus(8'h00, 0, 1, 2'd3, 32'h0);
`endif

        // Asynchronous reset in the middle of service
        applyStimulus(8'h00, 0, 1, 2'd0, 32'h08);
        applyStimulus(8'h08, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 0, 0, 2'd0, 32'h0);
        applyStimulus(8'h00, 1, 0, 2'd0, 32'h0);
        checkOutput("t7 in service before reset", 32'(in_service), 32'd1);
        checkOutput("t7 vector before reset", vector, 32'h20C);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("t7 intr in reset", 32'(intr), 32'd0);
        checkOutput("t7 in_service in reset", 32'(in_service), 32'd0);
        checkOutput("t7 vector in reset", vector, VB);
        readReg(2'd0, rd); checkOutput("t7 MASK in reset", rd, 32'd0);
        readReg(2'd2, rd); checkOutput("t7 MODE in reset", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef NESTED_INTR_EN
        // Random traffic compared cycle by cycle with the reference model
        rIrq = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                readReg(2'($urandom_range(0, 3)), rd);
                case (io_addr)
                    2'd0:    checkOutput("rnd MASK", rd, mMask);
                    2'd1:    checkOutput("rnd PEND", rd, mPend);
                    2'd2:    checkOutput("rnd MODE", rd, mMode);
                    default: checkOutput("rnd VEC", rd, mVec);
                endcase
            end
            if ($urandom_range(0, 2) == 0) rIrq = N'($urandom);
            op = int'($urandom_range(0, 15));
            if (op < 2) applyStimulus(rIrq, $urandom_range(0, 3) == 0, 1, 2'($urandom_range(0, 3)), $urandom);
            else if (op == 2) applyStimulus(rIrq, $urandom_range(0, 3) == 0, 1, 2'd3, 32'h0);
            else applyStimulus(rIrq, $urandom_range(0, 3) == 0, 0, 2'd0, 32'h0);
            checkOutput("rnd intr", 32'(intr), 32'(mAsking));
            checkOutput("rnd in_service", 32'(in_service), 32'(mServing));
            checkOutput("rnd vector", vector, mVec);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
